// File: rtl/jedro_1_ifu_pkg.sv
// jedro_1 shared definitions.
// Boot vector, canonical NOP and the fetch-buffer entry layout.
package jedro_1_defines;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// jedro_1 prefetch FIFO.
// Synchronous buffer; flush beats push and pop.
module jedro_1_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // At full, a push is only taken together with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit.
// PC, one-deep ROM request tracking, prefetch buffer, redirect flush.
module jedro_1_ifu
  import jedro_1_defines::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = jedro_1_defines::BOOT_ADDR,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic [ADDR_WIDTH-1:0] instr_mem_addr_o,
  output logic                  instr_mem_en_o,
  input  logic [DATA_WIDTH-1:0] instr_mem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o,
  input  logic                  decoder_ready_i,
  input  logic                  jmp_instr_i,
  input  logic [ADDR_WIDTH-1:0] jmp_address_i
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  squash_q, squash_d;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  full, empty;
  logic                  issue, push, pop;
  logic [EW-1:0]         wdata, rdata;
  logic                  unused_jmp_lsb;

  assign unused_jmp_lsb = ^{jmp_address_i[1:0], full};

  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight_q};

  // Gated by rstn_i so the ROM sees no request while reset is held.
  assign issue = rstn_i & ~jmp_instr_i & (occ < DEPTH_L);
  assign push  = inflight_q & ~squash_q & ~jmp_instr_i;
  assign pop   = instr_valid_o & decoder_ready_i;

  assign instr_mem_en_o   = issue;
  assign instr_mem_addr_o = pc_q;
  assign instr_valid_o    = ~empty & ~jmp_instr_i;
  assign wdata            = {req_addr_q, instr_mem_rdata_i};
  assign instr_addr_o     = rdata[EW-1:DATA_WIDTH];
  assign instr_o          = rdata[DATA_WIDTH-1:0];

  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = issue;
    squash_d   = jmp_instr_i & inflight_q;
    unique case (1'b1)
      jmp_instr_i: pc_d = {jmp_address_i[ADDR_WIDTH-1:2], 2'b00};
      issue: begin
        pc_d       = pc_q + ADDR_WIDTH'(4);
        req_addr_d = pc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q       <= BOOT_ADDR;
      req_addr_q <= BOOT_ADDR;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  jedro_1_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (jmp_instr_i),
    .data_i  (wdata),
    .data_o  (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_jedro_1_ifu.sv
// jedro_1_ifu bench: directed fetch, stall, redirect, reset
// and random-backpressure sequence checks against a ROM model.
module tb_jedro_1_ifu;

  logic        clk;
  logic        rstn;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        valid;
  logic        ready;
  logic        jmp;
  logic [31:0] jmp_addr;

  int n_chk;
  int n_pass;
  logic mon_en;
  logic [31:0] qa [$];
  logic [31:0] qi [$];

  jedro_1_ifu dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .instr_mem_addr_o  (mem_addr),
    .instr_mem_en_o    (mem_en),
    .instr_mem_rdata_i (mem_rdata),
    .instr_o           (instr),
    .instr_addr_o      (instr_addr),
    .instr_valid_o     (valid),
    .decoder_ready_i   (ready),
    .jmp_instr_i       (jmp),
    .jmp_address_i     (jmp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'h0010_0093;
      32'h4:   rom = 32'h0020_8113;
      default: rom = (a << 10) | 32'h13;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom(mem_addr);
  end

  always @(negedge clk) begin
    if (mon_en && rstn && valid && ready) begin
      qa.push_back(instr_addr);
      qi.push_back(instr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rstn  = 1'b0;
    jmp   = 1'b0;
    ready = rdy;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    for (i = 0; i < 20; i++) begin
      if (valid) break;
      tick();
      #1;
    end
    if (i == 20) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] seen [8];
    n_chk     = 0;
    n_pass    = 0;
    mon_en    = 1'b0;
    jmp_addr  = '0;
    mem_rdata = '0;
    rstn      = 1'b0;
    jmp       = 1'b0;
    ready     = 1'b1;
    #12;
    chk("rst_en", {31'd0, mem_en}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_iaddr", instr_addr, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);

    // First fetch, ready high.
    do_reset(1'b1);
    #1;
    chk("t1_en0", {31'd0, mem_en}, 32'd1);
    chk("t1_maddr0", mem_addr, 32'h0);
    tick(); #1;
    chk("t1_valid_c1", {31'd0, valid}, 32'd0);
    chk("t1_maddr1", mem_addr, 32'h4);
    tick(); #1;
    chk("t1_valid_c2", {31'd0, valid}, 32'd1);
    chk("t1_iaddr0", instr_addr, 32'h0);
    chk("t1_instr0", instr, 32'h0010_0093);
    tick(); #1;
    chk("t1_valid_c3", {31'd0, valid}, 32'd1);
    chk("t1_iaddr1", instr_addr, 32'h4);
    chk("t1_instr1", instr, 32'h0020_8113);

    // Stall: exactly four requests fill the buffer.
    do_reset(1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_en) begin
        if (n < 8) seen[n] = mem_addr;
        n++;
      end
      tick();
    end
    #1;
    chk("t2_nreq", n, 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_reqaddr", seen[i], 32'(i * 4));
    chk("t2_en_full", {31'd0, mem_en}, 32'd0);
    chk("t2_head", instr_addr, 32'h0);
    ready = 1'b1;
    tick(); #1;
    chk("t2_pop1", instr_addr, 32'h4);
    chk("t2_resume_en", {31'd0, mem_en}, 32'd1);
    chk("t2_resume_addr", mem_addr, 32'h10);
    tick(); #1;
    chk("t2_pop2", instr_addr, 32'h8);
    tick(); #1;
    chk("t2_pop3", instr_addr, 32'hC);
    chk("t2_pop3_word", instr, rom(32'hC));

    // Redirect while the 0x8 response is on the bus.
    do_reset(1'b0);
    tick(); tick();
    #1;
    chk("t3_req8", mem_addr, 32'h8);
    tick();
    jmp      = 1'b1;
    jmp_addr = 32'h40;
    #1;
    chk("t3_jvalid", {31'd0, valid}, 32'd0);
    chk("t3_jen", {31'd0, mem_en}, 32'd0);
    tick();
    jmp = 1'b0;
    #1;
    chk("t3_tgt_en", {31'd0, mem_en}, 32'd1);
    chk("t3_tgt_addr", mem_addr, 32'h40);
    chk("t3_flushed", {31'd0, valid}, 32'd0);
    ready = 1'b1;
    tick(); #1;
    chk("t3_lat", {31'd0, valid}, 32'd0);
    tick(); #1;
    chk("t3_valid", {31'd0, valid}, 32'd1);
    chk("t3_iaddr", instr_addr, 32'h40);
    chk("t3_instr", instr, rom(32'h40));
    tick(); #1;
    chk("t3_next", instr_addr, 32'h44);

    // Misaligned target, then back-to-back redirects.
    jmp      = 1'b1;
    jmp_addr = 32'h43;
    tick();
    jmp = 1'b0;
    #1;
    chk("t4_align", mem_addr, 32'h40);
    jmp      = 1'b1;
    jmp_addr = 32'h80;
    tick();
    jmp_addr = 32'hC0;
    tick();
    jmp = 1'b0;
    #1;
    chk("t4_last_wins", mem_addr, 32'hC0);
    wait_valid("t4");
    chk("t4_first", instr_addr, 32'hC0);

    // Asynchronous reset with a full buffer.
    do_reset(1'b0);
    repeat (7) tick();
    #1;
    chk("t5_full_valid", {31'd0, valid}, 32'd1);
    chk("t5_full_en", {31'd0, mem_en}, 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    chk("t5_valid", {31'd0, valid}, 32'd0);
    chk("t5_instr", instr, 32'd0);
    chk("t5_iaddr", instr_addr, 32'd0);
    chk("t5_en", {31'd0, mem_en}, 32'd0);
    chk("t5_maddr", mem_addr, 32'd0);
    tick();
    rstn  = 1'b1;
    ready = 1'b1;
    #1;
    chk("t5_boot_en", {31'd0, mem_en}, 32'd1);
    chk("t5_boot_addr", mem_addr, 32'h0);
    tick(); tick(); #1;
    chk("t5_first", instr_addr, 32'h0);

    // Random backpressure on a linear program.
    do_reset(1'b0);
    qa.delete();
    qi.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    mon_en = 1'b0;
    ready  = 1'b0;
    chk("t6_len", {31'd0, qa.size() > 40}, 32'd1);
    if (qa.size() > 0) chk("t6_start", qa[0], 32'h0);
    for (int i = 0; i < qa.size(); i++) begin
      if (i > 0) chk("t6_step", qa[i], qa[i-1] + 32'd4);
      chk("t6_word", qi[i], rom(qa[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jedro_1_ifu.md
Name: jedro_1_ifu

Overview:
- Instruction fetch unit of the jedro_1 core. Sits between the synchronous instruction ROM and the decoder.
- Generates word-aligned fetch addresses and buffers returned words in a small prefetch FIFO.
- Presents instructions to the decoder over a valid/ready handshake.
- Redirects the program counter and flushes all wrong-path state on a jump or branch from the execute stage.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte address width.
- BOOT_ADDR, 32'h0000_0000, PC value after reset.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  core clock.
- rstn_i  in  1  asynchronous reset, active low.
- instr_mem_addr_o  out  ADDR_WIDTH  ROM byte address.
- instr_mem_en_o  out  1  read request this cycle.
- instr_mem_rdata_i  in  DATA_WIDTH  ROM read data; valid exactly one cycle after the request.
- instr_o  out  DATA_WIDTH  instruction to the decoder.
- instr_addr_o  out  ADDR_WIDTH  PC of instr_o.
- instr_valid_o  out  1  instr_o/instr_addr_o are valid.
- decoder_ready_i  in  1  decoder accepts this cycle.
- jmp_instr_i  in  1  redirect request from execute.
- jmp_address_i  in  ADDR_WIDTH  redirect target.

Behaviour:
- Reset: one clock, clk_i; reset rstn_i is asynchronous, active low.
  - On reset: fetch_pc = BOOT_ADDR, FIFO empty, in-flight flag 0, instr_mem_en_o = 0, instr_valid_o = 0, instr_o = 0, instr_addr_o = 0, instr_mem_addr_o = BOOT_ADDR.
  - Reset asserted mid-operation discards everything immediately. The first request after release is to BOOT_ADDR, issued on the first rising edge after rstn_i deasserts.
- Issue rule: request in a cycle iff (fifo_count + inflight) < FIFO_DEPTH and jmp_instr_i = 0.
  - On issue: instr_mem_addr_o = fetch_pc, instr_mem_en_o = 1, and fetch_pc advances by 4 at the edge.
  - fetch_pc wraps modulo 2^ADDR_WIDTH, with no special handling.
- Response: inflight set on issue. The next cycle, {instr_mem_rdata_i, issued address} is pushed into the FIFO and inflight clears, unless the response was squashed.
  - Back-to-back issue is allowed: at most one request is outstanding at each edge.
- Output: instr_valid_o = FIFO non-empty and no jump in this cycle. instr_o/instr_addr_o = FIFO head.
  - Pop when instr_valid_o & decoder_ready_i.
  - No combinational path from instr_mem_rdata_i to instr_o: minimum ROM-to-decoder latency is 2 cycles after the request.
  - First instruction after reset: request at edge 1, pushed at edge 2, instr_valid_o high after edge 2.
- FIFO full: issue stops. A simultaneous pop and push at full is allowed, and the count is unchanged.
- FIFO empty with ready high: instr_valid_o = 0 and nothing is popped.
- Jump (jmp_instr_i = 1), highest priority:
  - In the same cycle: instr_valid_o forced 0, no pop, no issue.
  - At the edge: FIFO flushed, any outstanding response marked squashed (dropped the following cycle, never pushed), fetch_pc = {jmp_address_i[ADDR_WIDTH-1:2], 2'b00}.
  - Misaligned-target detection belongs to execute; the IFU only clears bits [1:0].
  - First target request is issued the cycle after the jump.
- Consecutive jump cycles: the last one wins, and each one squashes again.
- Squash flag clears when the squashed response cycle passes or on reset.

Decomposition:
- Package jedro_1_defines: BOOT_ADDR default, INSTR_NOP (32'h0000_0013), fetch-entry struct {addr, instr}.
- Sub-module jedro_1_fifo: parameterised synchronous FIFO with an async active-low reset.
  - Ports: push, pop, flush, full, empty, count, data in/out.
  - Flush has priority over push and pop.
- The IFU top holds the PC, inflight/squash flags and the issue logic.

Test Plan:
- Reset release, ROM holds 0x00100093 at 0x0 and 0x00208113 at 0x4, ready = 1: instr_valid_o rises 2 cycles after the first request; instr_addr_o = 0x0 then 0x4, with matching words in order and no gaps.
- Ready held 0 for 10 cycles: exactly FIFO_DEPTH = 4 requests (0x0, 0x4, 0x8, 0xC), then instr_mem_en_o = 0. On ready = 1, words pop in order and fetch resumes at 0x10.
- Jump to 0x40 while an outstanding response for 0x8 exists: the 0x8 word never appears, instr_valid_o = 0 during the jump cycle, next presented instr_addr_o = 0x40.
- Jump to 0x43: fetch address 0x40. Jumps in two consecutive cycles (0x80, then 0xC0): first delivered address is 0xC0.
- Assert rstn_i = 0 asynchronously mid-stream with a full FIFO: outputs reach reset values without a clock edge; after release, refetch starts at BOOT_ADDR.
- Random ready toggling over 200 cycles on a linear program: the delivered address sequence is strictly +4, with no duplicates or drops.
